// File: rtl/pram_banked.sv
// Banked program/data RAM: NUM_BANKS x 1024x32 single-port macros in one flat byte space,
// with req/ready/rvalid handshake, byte-enable writes, range error and optional zero-clear.
module pram_banked #(
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned ADDR_W    = 16,
    parameter bit          CLEAR_EN  = 1'b0,
    parameter string       INITFILE0 = "mem.txt",
    parameter string       INITFILE1 = "none",
    parameter string       INITFILE2 = "none",
    parameter string       INITFILE3 = "none",
    parameter string       INITFILE4 = "none",
    parameter string       INITFILE5 = "none",
    parameter string       INITFILE6 = "none",
    parameter string       INITFILE7 = "none"
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              ready_o,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam int unsigned BSEL_W  = $clog2(NUM_BANKS);
    localparam int unsigned BSEL_WX = (BSEL_W == 0) ? 1 : BSEL_W;

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t               r_state, w_state_nxt;
    logic [9:0]           r_cnt, w_cnt_nxt;
    logic [BSEL_WX-1:0]   w_bank, r_bank;
    logic                 w_in_range, w_acc, r_rvalid, r_err;
    logic [NUM_BANKS-1:0] w_cs;
    logic                 w_we, w_re;
    logic [31:0]          w_bm, w_dw, w_rsel;
    logic [9:0]           w_maddr;
    logic [31:0]          w_dr [NUM_BANKS];
    logic                 w_unused_lo;

    assign w_unused_lo = ^addr_i[1:0];

    if (BSEL_W == 0) begin : g_one_bank
        assign w_bank = '0;
    end else begin : g_multi_bank
        assign w_bank = addr_i[12 +: BSEL_W];
    end

    if (ADDR_W > 12 + BSEL_W) begin : g_hi_bits
        assign w_in_range = (addr_i[ADDR_W-1:12+BSEL_W] == '0);
    end else begin : g_no_hi_bits
        assign w_in_range = 1'b1;
    end

    assign ready_o = (r_state == S_IDLE);
    assign busy_o  = (r_state == S_CLEAR);
    assign w_acc   = req_i & ready_o & res_n;

    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_state  <= CLEAR_EN ? S_CLEAR : S_IDLE;
            r_cnt    <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_bank   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rvalid <= w_acc & ~we_i;
            r_err    <= w_acc & ~w_in_range;
            r_bank   <= w_bank;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cs        = '0;
        w_we        = 1'b0;
        w_re        = 1'b0;
        w_bm        = '0;
        w_dw        = '0;
        w_maddr     = addr_i[11:2];
        case (r_state)
            S_CLEAR: begin
                w_cs      = '1;
                w_we      = 1'b1;
                w_bm      = '1;
                w_maddr   = r_cnt;
                w_cnt_nxt = r_cnt + 10'd1;
                if (r_cnt == 10'd1023) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (w_acc && w_in_range) begin
                    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                        w_cs[b] = (w_bank == b[BSEL_WX-1:0]);
                    end
                    w_we = we_i;
                    w_re = ~we_i;
                    w_bm = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
                    w_dw = wdata_i;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Response outputs are gated by res_n so a response pending at reset is dropped.
    assign rvalid_o = r_rvalid & res_n;
    assign err_o    = r_err & res_n;

    always_comb begin
        w_rsel = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (r_bank == b[BSEL_WX-1:0]) w_rsel = w_dr[b];
        end
    end

    assign rdata_o = (rvalid_o && !r_err) ? w_rsel : '0;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        localparam string INIT = (g == 0) ? INITFILE0 : (g == 1) ? INITFILE1 :
                                 (g == 2) ? INITFILE2 : (g == 3) ? INITFILE3 :
                                 (g == 4) ? INITFILE4 : (g == 5) ? INITFILE5 :
                                 (g == 6) ? INITFILE6 : INITFILE7;
        HM_1P_GF28SLP_1024x32_1cr #(
            .INITFILE(INIT)
        ) u_mem (
            .CLK    (clk),
            .CS_I   (w_cs[g]),
            .WE_I   (w_we),
            .RE_I   (w_re),
            .ADDR_I (w_maddr),
            .BM_I   (w_bm),
            .DW_I   (w_dw),
            .DLYL   (2'b00),
            .DLYH   (2'b00),
            .DLYCLK (1'b0),
            .DR_O   (w_dr[g])
        );
    end

endmodule

// Behavioural stand-in for the 1024x32 single-port SRAM macro: bit-masked write,
// registered read with 1-cycle latency; the delay-trim pins have no functional effect.
module HM_1P_GF28SLP_1024x32_1cr #(
    parameter string INITFILE = "none"
) (
    input  logic        CLK,
    input  logic        CS_I,
    input  logic        WE_I,
    input  logic        RE_I,
    input  logic [9:0]  ADDR_I,
    input  logic [31:0] BM_I,
    input  logic [31:0] DW_I,
    input  logic [1:0]  DLYL,
    input  logic [1:0]  DLYH,
    input  logic        DLYCLK,
    output logic [31:0] DR_O
);

    logic [31:0] r_mem [1024];
    logic        w_unused_dly;

    assign w_unused_dly = ^{DLYL, DLYH, DLYCLK};

    always_ff @(posedge CLK) begin
        if (CS_I) begin
            if (WE_I) r_mem[ADDR_I] <= (r_mem[ADDR_I] & ~BM_I) | (DW_I & BM_I);
            if (RE_I) DR_O <= r_mem[ADDR_I];
        end
    end

endmodule

// File: tb/tb_pram_banked.sv
// Directed bench for pram_banked (4 banks, 16-bit address, zero-clear enabled).
module tb_pram_banked;

    logic        clk = 1'b0;
    logic        res_n, req_i, we_i;
    logic [3:0]  be_i;
    logic [15:0] addr_i;
    logic [31:0] wdata_i, rdata_o;
    logic        ready_o, rvalid_o, err_o, busy_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pram_banked #(
        .NUM_BANKS(4),
        .ADDR_W   (16),
        .CLEAR_EN (1'b1)
    ) dut (
        .clk     (clk),
        .res_n   (res_n),
        .req_i   (req_i),
        .we_i    (we_i),
        .be_i    (be_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .ready_o (ready_o),
        .rvalid_o(rvalid_o),
        .rdata_o (rdata_o),
        .err_o   (err_o),
        .busy_o  (busy_o)
    );

    typedef struct {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        rv;
        logic        er;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input logic rq, input logic w, input logic [3:0] b,
                                input logic [15:0] a, input logic [31:0] d,
                                input logic rv, input logic er, input logic [31:0] rd);
        vec_t v;
        v.req = rq; v.we = w; v.be = b; v.addr = a; v.wdata = d;
        v.rv = rv; v.er = er; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One cycle: drive just after the rising edge, return at the falling edge for sampling.
    task automatic apply(input logic rn, input logic rq, input logic w, input logic [3:0] b,
                         input logic [15:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        res_n = rn; req_i = rq; we_i = w; be_i = b; addr_i = a; wdata_i = d;
        @(negedge clk);
    endtask

    // Holds a read request to 0x0004 while the clear runs; returns in the first non-busy cycle.
    task automatic run_clear(output int cyc, output int bad_rdy, output int bad_rv);
        cyc = 0; bad_rdy = 0; bad_rv = 0;
        apply(1'b1, 1'b1, 1'b0, 4'hF, 16'h0004, 32'h0);
        while (busy_o && cyc < 2000) begin
            cyc++;
            if (ready_o) bad_rdy++;
            if (rvalid_o || err_o) bad_rv++;
            apply(1'b1, 1'b1, 1'b0, 4'hF, 16'h0004, 32'h0);
        end
    endtask

    initial begin
        int cyc, bad_rdy, bad_rv, bad;
        logic [3:0] ecs;

        vecs[0]  = mk(1, 0, 4'hF, 16'h0000, 32'h0,        0, 0, 32'h0);
        vecs[1]  = mk(1, 0, 4'hF, 16'h1FFC, 32'h0,        1, 0, 32'h0);
        vecs[2]  = mk(1, 0, 4'hF, 16'h3FFC, 32'h0,        1, 0, 32'h0);
        vecs[3]  = mk(1, 1, 4'hF, 16'h0004, 32'h11110001, 1, 0, 32'h0);
        vecs[4]  = mk(1, 1, 4'hF, 16'h1004, 32'h22220002, 0, 0, 32'h0);
        vecs[5]  = mk(1, 1, 4'hF, 16'h2004, 32'h33330003, 0, 0, 32'h0);
        vecs[6]  = mk(1, 1, 4'hF, 16'h3004, 32'h44440004, 0, 0, 32'h0);
        vecs[7]  = mk(1, 0, 4'hF, 16'h3004, 32'h0,        0, 0, 32'h0);
        vecs[8]  = mk(1, 0, 4'hF, 16'h0004, 32'h0,        1, 0, 32'h44440004);
        vecs[9]  = mk(1, 0, 4'hF, 16'h2004, 32'h0,        1, 0, 32'h11110001);
        vecs[10] = mk(1, 0, 4'hF, 16'h1004, 32'h0,        1, 0, 32'h33330003);
        vecs[11] = mk(1, 1, 4'hF, 16'h0010, 32'h11223344, 1, 0, 32'h22220002);
        vecs[12] = mk(1, 1, 4'h5, 16'h0010, 32'hAABBCCDD, 0, 0, 32'h0);
        vecs[13] = mk(1, 0, 4'hF, 16'h0010, 32'h0,        0, 0, 32'h0);
        vecs[14] = mk(1, 0, 4'hF, 16'h4000, 32'h0,        1, 0, 32'h11BB33DD);
        vecs[15] = mk(1, 1, 4'hF, 16'h8000, 32'hDEADBEEF, 1, 1, 32'h0);
        vecs[16] = mk(1, 1, 4'hF, 16'h0020, 32'h12345678, 0, 1, 32'h0);
        vecs[17] = mk(1, 0, 4'hF, 16'h0020, 32'h0,        0, 0, 32'h0);
        vecs[18] = mk(1, 0, 4'hF, 16'h0020, 32'h0,        1, 0, 32'h12345678);
        vecs[19] = mk(1, 1, 4'hF, 16'h0020, 32'hCAFEF00D, 1, 0, 32'h12345678);
        vecs[20] = mk(1, 0, 4'hF, 16'h0020, 32'h0,        0, 0, 32'h0);
        vecs[21] = mk(1, 1, 4'h0, 16'h0014, 32'hFFFFFFFF, 1, 0, 32'hCAFEF00D);
        vecs[22] = mk(1, 0, 4'hF, 16'h0014, 32'h0,        0, 0, 32'h0);
        vecs[23] = mk(0, 0, 4'h0, 16'h0000, 32'h0,        1, 0, 32'h0);

        res_n = 1'b0; req_i = 1'b0; we_i = 1'b0; be_i = '0; addr_i = '0; wdata_i = '0;

        apply(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        apply(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        chk("reset busy",   32'(busy_o),   32'd1);
        chk("reset ready",  32'(ready_o),  32'd0);
        chk("reset rvalid", 32'(rvalid_o), 32'd0);
        chk("reset err",    32'(err_o),    32'd0);
        chk("reset rdata",  rdata_o,       32'h0);

        run_clear(cyc, bad_rdy, bad_rv);
        chk("clear cycles",      32'(cyc),     32'd1024);
        chk("clear ready low",   32'(bad_rdy), 32'd0);
        chk("clear no response", 32'(bad_rv),  32'd0);
        chk("ready after clear", 32'(ready_o), 32'd1);
        apply(1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        chk("post-clear rvalid", 32'(rvalid_o), 32'd1);
        chk("post-clear rdata",  rdata_o,       32'h0);

        for (int i = 0; i < 24; i++) begin
            apply(1'b1, vecs[i].req, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata);
            ecs = (vecs[i].req && vecs[i].addr[15:14] == 2'b00) ? (4'b0001 << vecs[i].addr[13:12]) : 4'b0000;
            chk($sformatf("row%0d rvalid", i), 32'(rvalid_o), 32'(vecs[i].rv));
            chk($sformatf("row%0d err", i),    32'(err_o),    32'(vecs[i].er));
            chk($sformatf("row%0d rdata", i),  rdata_o,       vecs[i].rd);
            chk($sformatf("row%0d ready", i),  32'(ready_o),  32'd1);
            chk($sformatf("row%0d cs", i),     32'(dut.w_cs), 32'(ecs));
        end

        // Read accepted, then reset in the very next cycle: the response must vanish.
        apply(1'b1, 1'b1, 1'b0, 4'hF, 16'h0004, 32'h0);
        apply(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        chk("rst drop rvalid", 32'(rvalid_o), 32'd0);
        chk("rst drop rdata",  rdata_o,       32'h0);
        apply(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        chk("rst2 busy",  32'(busy_o),  32'd1);
        chk("rst2 ready", 32'(ready_o), 32'd0);

        bad = 0;
        for (int i = 0; i < 500; i++) begin
            apply(1'b1, 1'b1, 1'b0, 4'hF, 16'h0004, 32'h0);
            if (!busy_o || ready_o || rvalid_o) bad++;
        end
        chk("partial clear", 32'(bad), 32'd0);
        apply(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);

        run_clear(cyc, bad_rdy, bad_rv);
        chk("reclear cycles",      32'(cyc),     32'd1024);
        chk("reclear ready low",   32'(bad_rdy), 32'd0);
        chk("reclear no response", 32'(bad_rv),  32'd0);
        apply(1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        chk("reclear rvalid", 32'(rvalid_o), 32'd1);
        chk("reclear rdata",  rdata_o,       32'h0);
        chk("reclear err",    32'(err_o),    32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
